rcastudioii_keypad: RTL
=======================

# rcastudioii_keypad

Converts the 11-bit toggle-strobed PS/2 key stream into the two 10-key hex keypads of the RCA Studio II. It presents key state to the 1802 CPU through the keypad-select latch and the EF3/EF4 flag inputs. It sits between the PS/2 key input of the top level and the `rcastudioii` core. It consumes `ps2_key` and produces per-pad "selected key pressed" flags. An optional minimum-hold stretcher guarantees that short taps are visible to CPU polling loops.

## Interface
- `MIN_HOLD`, default 24'd480000, minimum asserted time of a key in clk cycles (10 ms at 48 MHz); used only with the stretcher compiled in.
- `HOLD_W`, default 24, width of the per-key hold counters; must hold `MIN_HOLD`.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `ps2_key`  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode.
- `key_sel_we`  in  1  one-cycle write of the keypad select latch (CPU OUT 2).
- `key_sel`  in  4  key index written with `key_sel_we`; values 0–9 are valid.
- `ef3_n`  out  1  low when the selected key on pad A is pressed.
- `ef4_n`  out  1  low when the selected key on pad B is pressed.
- `keys_a`  out  10  pad A effective key state, bit n = digit n.
- `keys_b`  out  10  pad B effective key state, bit n = digit n.

## Operation
- Event detect: `strb_q` registers `ps2_key[10]`. An event occurs on any cycle where `ps2_key[10] != strb_q`. Reset loads `strb_q` with the current `ps2_key[10]`, so no spurious event follows reset.
- Decode applies to non-extended codes only (`[8]=0`). Extended events are dropped.
- Pad A uses the main-row digits: 0x45→0, 0x16→1, 0x1E→2, 0x26→3, 0x25→4, 0x2E→5, 0x36→6, 0x3D→7, 0x3E→8, 0x46→9.
- Pad B uses the keypad digits: 0x70→0, 0x69→1, 0x72→2, 0x7A→3, 0x6B→4, 0x73→5, 0x74→6, 0x6C→7, 0x75→8, 0x7D→9.
- Unmapped scancodes are ignored.
- Raw state: a decoded event sets `raw[pad][n]` to `ps2_key[9]`. Events for other keys leave other bits untouched. Multiple keys may be down at once.
- Select latch: `sel_q` loads `key_sel` on `key_sel_we`. Reset value is 4'hF.
- If `sel_q` > 9, both flags are inactive (high).
- Flags: `ef3_n = ~keys_a[sel_q]` and `ef4_n = ~keys_b[sel_q]`, both registered.
- Reset values: `ef3_n`=1, `ef4_n`=1, `keys_a`=0, `keys_b`=0, raw state, counters and `sel_q` cleared to their reset values.
- Reset asserted mid-operation clears everything immediately. Keys held across reset read released until their next press event.

## Timing
- PS/2 toggle to `raw` update: 1 cycle (the event is decoded in the toggle cycle and registered at the next edge).
- `raw` to `keys_a`/`keys_b`: 1 cycle.
- Any change of `keys_*` or `sel_q` to `ef*_n`: 1 cycle.
- Total latency from toggle to flag: 3 cycles.
- Select write to flag: 2 cycles (latch, then flag register).
- `key_sel_we` and a key event in the same cycle are independent; both take effect.
- Back-to-back toggles on consecutive cycles are each processed. There is no buffering and no back-pressure.

## Configuration
- `RCASTUDIOII_KEYPAD_HOLD_EN` defined:
  - Each of the 20 keys has a `HOLD_W` counter.
  - A press reloads the counter to `MIN_HOLD`. The counter decrements to 0 while nonzero.
  - `keys_*[n] = raw[n] | (cnt[n] != 0)`.
  - A press and an expiry in the same cycle: the reload wins.
  - A release before expiry keeps the key asserted until the counter reaches 0.
  - A re-press during the hold reloads the counter.
- Undefined:
  - No counters are built. `keys_*` equals `raw`.
  - `MIN_HOLD` and `HOLD_W` are unused.

## Structure
- Package `rcastudioii_pkg` holds:
  - the scancode constants for both pad maps;
  - the `KEY_NONE` select value (4'hF);
  - a `pad_e` enum (PAD_A, PAD_B);
  - a typedef for the 11-bit ps2_key fields.
- One sub-module, `rcastudioii_key_hold`: a single-key reload/decrement stretcher. It is instantiated 20 times under the macro.
- The decode is a combinational function in the package that returns {valid, pad, index}.

## Test plan
- Reset, then toggle `ps2_key` = {1,1,0,8'h16} and write `key_sel`=1 → `keys_a`=10'h002 and `ef3_n`=0 three cycles after the toggle; `ef4_n` stays 1.
- Press keypad 0x7D (9) with `key_sel`=9, then release 5 cycles later, without the macro → `ef4_n` goes low at cycle 3 and returns high 3 cycles after the release toggle.
- Same tap with the macro defined and `MIN_HOLD`=100 → `keys_b[9]` stays asserted for exactly 100 cycles after the press load; a re-press at cycle 50 extends it to cycle 150.
- Extended 0x70 (`[8]`=1) and unmapped 0x1C → no change in `keys_a`/`keys_b`.
- Press digits 3 and 5 on pad A, then write `key_sel` = 3, 5, 4, 12 → `ef3_n` = 0, 0, 1, 1 respectively, each valid 2 cycles after its write.
- Assert `reset_n`=0 while keys are held and a hold count is running → all outputs return to reset values next cycle; no event is generated on release of reset.

Source files
------------

// File: rtl/rcastudioii_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rcastudioii_pkg
// Description : Shared types, scancode maps and key decode for the RCA
//               Studio II keypad bridge.
// Revision    : 1.0  initial release
// ============================================================================
package rcastudioii_pkg;

    // Select latch value meaning "no key selected"
    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam int         NUM_KEYS = 10;

    typedef enum logic {
        PAD_A = 1'b0,
        PAD_B = 1'b1
    } pad_e;

    // Field view of the 11-bit toggle-strobed PS/2 key word
    typedef struct packed {
        logic       strobe;
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } ps2_key_t;

    // Decode result: which pad and digit a scancode maps to
    typedef struct packed {
        logic       valid;
        pad_e       pad;
        logic [3:0] index;
    } key_dec_t;

    // Pad A: main-row digits 0-9
    localparam logic [7:0] SC_A0 = 8'h45;
    localparam logic [7:0] SC_A1 = 8'h16;
    localparam logic [7:0] SC_A2 = 8'h1E;
    localparam logic [7:0] SC_A3 = 8'h26;
    localparam logic [7:0] SC_A4 = 8'h25;
    localparam logic [7:0] SC_A5 = 8'h2E;
    localparam logic [7:0] SC_A6 = 8'h36;
    localparam logic [7:0] SC_A7 = 8'h3D;
    localparam logic [7:0] SC_A8 = 8'h3E;
    localparam logic [7:0] SC_A9 = 8'h46;

    // Pad B: numeric keypad digits 0-9
    localparam logic [7:0] SC_B0 = 8'h70;
    localparam logic [7:0] SC_B1 = 8'h69;
    localparam logic [7:0] SC_B2 = 8'h72;
    localparam logic [7:0] SC_B3 = 8'h7A;
    localparam logic [7:0] SC_B4 = 8'h6B;
    localparam logic [7:0] SC_B5 = 8'h73;
    localparam logic [7:0] SC_B6 = 8'h74;
    localparam logic [7:0] SC_B7 = 8'h6C;
    localparam logic [7:0] SC_B8 = 8'h75;
    localparam logic [7:0] SC_B9 = 8'h7D;

    // Map a scancode to {valid, pad, index}; extended codes never map
    function automatic key_dec_t decode_key(input logic extended, input logic [7:0] code);
        key_dec_t d;
        d.valid = 1'b1;
        d.pad   = PAD_A;
        d.index = 4'd0;
        if (extended) begin
            d.valid = 1'b0;
        end else begin
            case (code)
                SC_A0: begin d.pad = PAD_A; d.index = 4'd0; end
                SC_A1: begin d.pad = PAD_A; d.index = 4'd1; end
                SC_A2: begin d.pad = PAD_A; d.index = 4'd2; end
                SC_A3: begin d.pad = PAD_A; d.index = 4'd3; end
                SC_A4: begin d.pad = PAD_A; d.index = 4'd4; end
                SC_A5: begin d.pad = PAD_A; d.index = 4'd5; end
                SC_A6: begin d.pad = PAD_A; d.index = 4'd6; end
                SC_A7: begin d.pad = PAD_A; d.index = 4'd7; end
                SC_A8: begin d.pad = PAD_A; d.index = 4'd8; end
                SC_A9: begin d.pad = PAD_A; d.index = 4'd9; end
                SC_B0: begin d.pad = PAD_B; d.index = 4'd0; end
                SC_B1: begin d.pad = PAD_B; d.index = 4'd1; end
                SC_B2: begin d.pad = PAD_B; d.index = 4'd2; end
                SC_B3: begin d.pad = PAD_B; d.index = 4'd3; end
                SC_B4: begin d.pad = PAD_B; d.index = 4'd4; end
                SC_B5: begin d.pad = PAD_B; d.index = 4'd5; end
                SC_B6: begin d.pad = PAD_B; d.index = 4'd6; end
                SC_B7: begin d.pad = PAD_B; d.index = 4'd7; end
                SC_B8: begin d.pad = PAD_B; d.index = 4'd8; end
                SC_B9: begin d.pad = PAD_B; d.index = 4'd9; end
                default: d.valid = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rcastudioii_key_hold.sv
`default_nettype none
// ============================================================================
// Module      : rcastudioii_key_hold
// Description : Single-key minimum-hold stretcher. A press reloads the
//               counter to MIN_HOLD; it then counts down to zero. The key
//               reads active while the count is nonzero.
// Revision    : 1.0  initial release
// ============================================================================
module rcastudioii_key_hold
    import rcastudioii_pkg::*;
#(
    parameter int unsigned         HOLD_W   = 24,
    parameter logic [HOLD_W-1:0]   MIN_HOLD = 24'd480000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic active
);

    logic [HOLD_W-1:0] cnt;

    // Reload on press (wins over expiry), otherwise count down to zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= MIN_HOLD;
        end else if (cnt != '0) begin
            cnt <= cnt - HOLD_W'(1);
        end
    end

    assign active = (cnt != '0);

endmodule
`default_nettype wire

// File: rtl/rcastudioii_keypad.sv
`default_nettype none
// ============================================================================
// Module      : rcastudioii_keypad
// Description : Converts the toggle-strobed PS/2 key stream into the two
//               10-key hex pads of the RCA Studio II and drives the EF3/EF4
//               "selected key pressed" flags for the 1802.
//               Optional feature macro: RCASTUDIOII_KEYPAD_HOLD_EN
//               (per-key minimum-hold stretcher).
// Revision    : 1.0  initial release
// ============================================================================
module rcastudioii_keypad
    import rcastudioii_pkg::*;
#(
    parameter int unsigned         HOLD_W   = 24,
    parameter logic [HOLD_W-1:0]   MIN_HOLD = 24'd480000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        key_sel_we,
    input  logic [3:0]  key_sel,
    output logic        ef3_n,
    output logic        ef4_n,
    output logic [9:0]  keys_a,
    output logic [9:0]  keys_b
);

    ps2_key_t    key_in;
    logic        strb_q;
    logic        key_event;
    key_dec_t    dec;
    logic        hit;
    logic [9:0]  raw_a;
    logic [9:0]  raw_b;
    logic [9:0]  eff_a;
    logic [9:0]  eff_b;
    logic [3:0]  sel_q;
    logic [15:0] keys_a_ext;
    logic [15:0] keys_b_ext;

    assign key_in    = ps2_key_t'(ps2_key);
    assign key_event = (key_in.strobe != strb_q);
    assign dec       = decode_key(key_in.extended, key_in.code);
    assign hit       = key_event & dec.valid;

    // Track the strobe; during reset it follows the input so release of
    // reset never looks like a toggle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            strb_q <= key_in.strobe;
        end else begin
            strb_q <= key_in.strobe;
        end
    end

    // Raw key state: a decoded event writes only its own bit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            raw_a <= '0;
            raw_b <= '0;
        end else if (hit) begin
            if (dec.pad == PAD_A) begin
                raw_a[dec.index] <= key_in.pressed;
            end else begin
                raw_b[dec.index] <= key_in.pressed;
            end
        end
    end

`ifdef RCASTUDIOII_KEYPAD_HOLD_EN
    logic [9:0] load_a;
    logic [9:0] load_b;
    logic [9:0] held_a;
    logic [9:0] held_b;

    // One-hot press strobe for the hold counter of the decoded key
    always_comb begin
        load_a = '0;
        load_b = '0;
        if (hit && key_in.pressed) begin
            if (dec.pad == PAD_A) begin
                load_a[dec.index] = 1'b1;
            end else begin
                load_b[dec.index] = 1'b1;
            end
        end
    end

    for (genvar n = 0; n < NUM_KEYS; n++) begin : g_hold
        rcastudioii_key_hold #(
            .HOLD_W   (HOLD_W),
            .MIN_HOLD (MIN_HOLD)
        ) u_hold_a (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load_a[n]),
            .active  (held_a[n])
        );
        rcastudioii_key_hold #(
            .HOLD_W   (HOLD_W),
            .MIN_HOLD (MIN_HOLD)
        ) u_hold_b (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load_b[n]),
            .active  (held_b[n])
        );
    end

    assign eff_a = raw_a | held_a;
    assign eff_b = raw_b | held_b;
`else
    assign eff_a = raw_a;
    assign eff_b = raw_b;
`endif

    // Register the effective key state seen by the CPU
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            keys_a <= '0;
            keys_b <= '0;
        end else begin
            keys_a <= eff_a;
            keys_b <= eff_b;
        end
    end

    // Keypad select latch written by CPU OUT 2
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q <= KEY_NONE;
        end else if (key_sel_we) begin
            sel_q <= key_sel;
        end
    end

    // Zero-extended to 16 entries so selects 10-15 read "not pressed"
    assign keys_a_ext = {6'b0, keys_a};
    assign keys_b_ext = {6'b0, keys_b};

    // Active-low flags for the selected key on each pad
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ef3_n <= 1'b1;
            ef4_n <= 1'b1;
        end else begin
            ef3_n <= ~keys_a_ext[sel_q];
            ef4_n <= ~keys_b_ext[sel_q];
        end
    end

endmodule
`default_nettype wire
